chronometer_bcd_counter: RTL and testbench

- Timebase and counting core of the simple chronometer; produces the live seconds value and a frozen lap value as 8-bit packed BCD.
- Also drives the select line of the downstream 2-input 8-bit display multiplexer: live time on input 0, lap time on input 1.
- Start/stop, clear and lap buttons arrive as debounced asynchronous levels; synchronisation and edge detection are done here.

---
 rtl/chronometer_pkg.sv | 19 +
 rtl/bcd_mod60_counter.sv | 60 ++++++
 rtl/chronometer_bcd_counter.sv | 174 +++++++++++++++++
 tb/tb_chronometer_bcd_counter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chronometer_pkg.sv
// Shared types and constants for the chronometer counting core.
//   chrono_state_e       : control FSM states (IDLE, RUNNING, STOPPED)
//   BCD_UNITS_MAX        : last legal units digit before carrying into tens
//   BCD_TENS_MAX         : last legal tens digit of a mod-60 BCD value
//   DEFAULT_TICK_DIVIDER : clock cycles per one-second tick for a 50 MHz clock
package chronometer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    STOPPED = 2'd2
  } chrono_state_e;

  localparam logic [3:0] BCD_UNITS_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX  = 4'd5;

  localparam int unsigned DEFAULT_TICK_DIVIDER = 50000000;

endpackage

// File: rtl/bcd_mod60_counter.sv
// Two-digit packed-BCD counter running 00..59.
//   clock     : system clock, rising edge
//   reset_n   : asynchronous active-low reset
//   clear     : synchronous zero, wins over increment
//   increment : advance by one when high
//   value     : [7:4] tens, [3:0] units
//   carry     : one-cycle registered pulse, high in the cycle value has just wrapped 59->00
module bcd_mod60_counter
  import chronometer_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       increment,
  output logic [7:0] value,
  output logic       carry
);

  logic [3:0] units_q, units_d;
  logic [3:0] tens_q, tens_d;
  logic       carry_q, carry_d;

  always_comb begin
    units_d = units_q;
    tens_d  = tens_q;
    carry_d = 1'b0;
    if (clear) begin
      units_d = 4'd0;
      tens_d  = 4'd0;
    end else if (increment) begin
      if (units_q == BCD_UNITS_MAX) begin
        units_d = 4'd0;
        if (tens_q == BCD_TENS_MAX) begin
          tens_d  = 4'd0;
          carry_d = 1'b1;
        end else begin
          tens_d = tens_q + 4'd1;
        end
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      units_q <= 4'd0;
      tens_q  <= 4'd0;
      carry_q <= 1'b0;
    end else begin
      units_q <= units_d;
      tens_q  <= tens_d;
      carry_q <= carry_d;
    end
  end

  assign value = {tens_q, units_q};
  assign carry = carry_q;

endmodule

// File: rtl/chronometer_bcd_counter.sv
// Chronometer timebase and counting core: synchronises the debounced buttons, runs the
// IDLE/RUNNING/STOPPED control FSM, divides the clock to a one-second tick and keeps the live
// and lap seconds as packed BCD. Also drives the live/lap display mux select.
//   clock, reset_n        : rising-edge clock, asynchronous active-low reset
//   start_stop_btn        : rising edge toggles run/stop
//   clear_btn             : rising edge returns to IDLE and zeroes everything
//   lap_btn               : rising edge toggles lap hold
//   live_seconds          : running seconds (BCD)
//   lap_seconds           : seconds captured at the last lap press (BCD)
//   live_minutes          : running minutes (BCD), 8'h00 unless CHRONO_MINUTES_EN is defined
//   display_select        : 0 shows live, 1 shows lap
//   minute_tick           : one-cycle pulse on the seconds 59->00 wrap
//   running               : high in RUNNING
// Build option: define CHRONO_MINUTES_EN to generate the minutes counter.
module chronometer_bcd_counter
  import chronometer_pkg::*;
#(
  parameter int unsigned TICK_DIVIDER = DEFAULT_TICK_DIVIDER
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start_stop_btn,
  input  logic       clear_btn,
  input  logic       lap_btn,
  output logic [7:0] live_seconds,
  output logic [7:0] lap_seconds,
  output logic [7:0] live_minutes,
  output logic       display_select,
  output logic       minute_tick,
  output logic       running
);

  localparam int unsigned PrescW = $clog2(TICK_DIVIDER);
  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIVIDER - 1);

  // Button order in the vectors below: [2] lap, [1] clear, [0] start/stop.
  logic [2:0] btn_raw;
  logic [2:0] sync1_q, sync2_q, prev_q;
  logic [2:0] btn_edge;
  logic       ss_edge, clear_edge, lap_edge;

  assign btn_raw = {lap_btn, clear_btn, start_stop_btn};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      prev_q  <= 3'b000;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign btn_edge   = sync2_q & ~prev_q;
  assign ss_edge    = btn_edge[0];
  assign clear_edge = btn_edge[1];
  assign lap_edge   = btn_edge[2];

  // Control FSM.
  chrono_state_e state_q, state_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_edge) begin
      state_d = IDLE;
    end else if (ss_edge) begin
      unique case (state_q)
        IDLE:    state_d = RUNNING;
        RUNNING: state_d = STOPPED;
        STOPPED: state_d = RUNNING;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    running = (state_q == RUNNING);
  end

  // Prescaler holds in STOPPED so a restart resumes the partial second.
  logic [PrescW-1:0] presc_q, presc_d;
  logic              tick;

  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (clear_edge) begin
      presc_d = '0;
    end else if (state_q == RUNNING) begin
      if (presc_q == PrescMax) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + PrescW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  bcd_mod60_counter u_seconds (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear_edge),
    .increment (tick),
    .value     (live_seconds),
    .carry     (minute_tick)
  );

  // Lap hold. Capturing the registered seconds means a coincident tick yields the
  // pre-increment value. Decisions use the current state, so a simultaneous start/stop edge
  // does not change what the lap edge does.
  logic [7:0] lap_q, lap_d;
  logic       sel_q, sel_d;

  always_comb begin
    lap_d = lap_q;
    sel_d = sel_q;
    if (clear_edge) begin
      lap_d = 8'h00;
      sel_d = 1'b0;
    end else if (lap_edge) begin
      if (sel_q) begin
        sel_d = 1'b0;
      end else if (state_q == RUNNING) begin
        lap_d = live_seconds;
        sel_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lap_q <= 8'h00;
      sel_q <= 1'b0;
    end else begin
      lap_q <= lap_d;
      sel_q <= sel_d;
    end
  end

  assign lap_seconds    = lap_q;
  assign display_select = sel_q;

`ifdef CHRONO_MINUTES_EN
  bcd_mod60_counter u_minutes (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear_edge),
    .increment (minute_tick),
    .value     (live_minutes),
    .carry     ()
  );
`else
  assign live_minutes = 8'h00;
`endif

endmodule

// File: tb/tb_chronometer_bcd_counter.sv
module tb_chronometer_bcd_counter;

  logic       clock;
  logic       reset_n;
  logic       start_stop_btn;
  logic       clear_btn;
  logic       lap_btn;
  logic [7:0] live_seconds;
  logic [7:0] lap_seconds;
  logic [7:0] live_minutes;
  logic       display_select;
  logic       minute_tick;
  logic       running;

  int checks = 0;
  int errors = 0;

  // {live_seconds, lap_seconds, live_minutes, display_select, minute_tick, running}
  logic [26:0] obs;
  logic [26:0] exp_v;
  assign obs = {live_seconds, lap_seconds, live_minutes, display_select, minute_tick, running};

`ifdef CHRONO_MINUTES_EN
  localparam logic [7:0] MinAfter60s = 8'h01;
`else
  localparam logic [7:0] MinAfter60s = 8'h00;
`endif

  chronometer_bcd_counter #(
    .TICK_DIVIDER (4)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start_stop_btn (start_stop_btn),
    .clear_btn      (clear_btn),
    .lap_btn        (lap_btn),
    .live_seconds   (live_seconds),
    .lap_seconds    (lap_seconds),
    .live_minutes   (live_minutes),
    .display_select (display_select),
    .minute_tick    (minute_tick),
    .running        (running)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Called 1 time unit after a rising edge; returns 1 time unit after the 3rd rising edge,
  // which is the edge at which the press takes effect.
  task automatic press(input logic [2:0] mask);
    @(negedge clock);
    {lap_btn, clear_btn, start_stop_btn} = mask;
    @(posedge clock);
    @(negedge clock);
    {lap_btn, clear_btn, start_stop_btn} = 3'b000;
    @(posedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    {lap_btn, clear_btn, start_stop_btn} = 3'b000;
    #2;
    checks++;
    if (obs !== 27'd0) begin
      $display("FAIL reset_values: got %h expected %h", obs, 27'd0);
      errors++;
    end
    @(negedge clock);
    reset_n = 1'b1;
    wait_cycles(3);
    checks++;
    if (obs !== 27'd0) begin
      $display("FAIL reset_idle: got %h expected %h", obs, 27'd0);
      errors++;
    end
  endtask

  task automatic test_basic_count;
    press(3'b001);
    exp_v = {8'h00, 8'h00, 8'h00, 3'b001};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL basic_start: got %h expected %h", obs, exp_v);
      errors++;
    end
    wait_cycles(236);
    exp_v = {8'h59, 8'h00, 8'h00, 3'b001};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL basic_59: got %h expected %h", obs, exp_v);
      errors++;
    end
    wait_cycles(3);
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL basic_59_hold: got %h expected %h", obs, exp_v);
      errors++;
    end
    wait_cycles(1);
    exp_v = {8'h00, 8'h00, 8'h00, 3'b011};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL basic_wrap: got %h expected %h", obs, exp_v);
      errors++;
    end
    wait_cycles(1);
    exp_v = {8'h00, 8'h00, MinAfter60s, 3'b001};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL basic_tick_end: got %h expected %h", obs, exp_v);
      errors++;
    end
    press(3'b010);
    checks++;
    if (obs !== 27'd0) begin
      $display("FAIL basic_clear: got %h expected %h", obs, 27'd0);
      errors++;
    end
  endtask

  task automatic test_stop_resume;
    press(3'b001);
    wait_cycles(27);
    press(3'b001);  // takes effect 30 cycles in: 7 s, prescaler 2
    exp_v = {8'h07, 8'h00, 8'h00, 3'b000};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL stop_value: got %h expected %h", obs, exp_v);
      errors++;
    end
    wait_cycles(50);
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL stop_hold: got %h expected %h", obs, exp_v);
      errors++;
    end
    press(3'b001);
    exp_v = {8'h07, 8'h00, 8'h00, 3'b001};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL resume_rise: got %h expected %h", obs, exp_v);
      errors++;
    end
    wait_cycles(1);
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL resume_plus1: got %h expected %h", obs, exp_v);
      errors++;
    end
    wait_cycles(1);
    exp_v = {8'h08, 8'h00, 8'h00, 3'b001};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL resume_plus2: got %h expected %h", obs, exp_v);
      errors++;
    end
    press(3'b010);
  endtask

  task automatic test_lap;
    press(3'b001);
    wait_cycles(47);
    press(3'b100);  // effect at 50 cycles: 12 s
    exp_v = {8'h12, 8'h12, 8'h00, 3'b101};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL lap_capture: got %h expected %h", obs, exp_v);
      errors++;
    end
    wait_cycles(10);
    exp_v = {8'h15, 8'h12, 8'h00, 3'b101};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL lap_live_runs: got %h expected %h", obs, exp_v);
      errors++;
    end
    press(3'b100);
    exp_v = {8'h15, 8'h12, 8'h00, 3'b001};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL lap_release: got %h expected %h", obs, exp_v);
      errors++;
    end
    press(3'b001);  // stop at 66 cycles: 16 s
    press(3'b100);  // ignored while stopped with live shown
    exp_v = {8'h16, 8'h12, 8'h00, 3'b000};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL lap_stopped_ignored: got %h expected %h", obs, exp_v);
      errors++;
    end
    press(3'b010);
  endtask

  task automatic test_priority;
    press(3'b001);
    wait_cycles(131);
    press(3'b110);  // clear and lap together at 134 cycles (33 s)
    checks++;
    if (obs !== 27'd0) begin
      $display("FAIL prio_clear_lap: got %h expected %h", obs, 27'd0);
      errors++;
    end
    press(3'b100);
    checks++;
    if (obs !== 27'd0) begin
      $display("FAIL prio_lap_idle: got %h expected %h", obs, 27'd0);
      errors++;
    end
    // start/stop and lap together, on the same cycle as a tick: stop, capture 02, live 03
    press(3'b001);
    wait_cycles(9);
    press(3'b101);
    exp_v = {8'h03, 8'h02, 8'h00, 3'b100};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL prio_stop_lap_tick: got %h expected %h", obs, exp_v);
      errors++;
    end
    press(3'b100);
    exp_v = {8'h03, 8'h02, 8'h00, 3'b000};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL lap_release_stopped: got %h expected %h", obs, exp_v);
      errors++;
    end
    press(3'b010);
  endtask

  task automatic test_async_reset;
    press(3'b001);
    wait_cycles(165);
    exp_v = {8'h41, 8'h00, 8'h00, 3'b001};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL areset_pre: got %h expected %h", obs, exp_v);
      errors++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== 27'd0) begin
      $display("FAIL areset_immediate: got %h expected %h", obs, 27'd0);
      errors++;
    end
    @(negedge clock);
    reset_n = 1'b1;
    wait_cycles(10);
    checks++;
    if (obs !== 27'd0) begin
      $display("FAIL areset_idle: got %h expected %h", obs, 27'd0);
      errors++;
    end
  endtask

`ifdef CHRONO_MINUTES_EN
  task automatic test_minutes_wrap;
    press(3'b001);
    wait_cycles(14396);
    exp_v = {8'h59, 8'h00, 8'h59, 3'b001};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL min_5959: got %h expected %h", obs, exp_v);
      errors++;
    end
    wait_cycles(4);
    exp_v = {8'h00, 8'h00, 8'h59, 3'b011};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL min_sec_wrap: got %h expected %h", obs, exp_v);
      errors++;
    end
    wait_cycles(1);
    exp_v = {8'h00, 8'h00, 8'h00, 3'b001};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL min_wrap: got %h expected %h", obs, exp_v);
      errors++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_count();
    test_stop_resume();
    test_lap();
    test_priority();
    test_async_reset();
`ifdef CHRONO_MINUTES_EN
    test_minutes_wrap();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
